spi_master: RTL and testbench

- SPI mode-0 initiator. It is the counterpart of the team's SPI peripheral-side shifter.
- Accepts a parallel word on a start strobe, then drives cs_n, sclk and mosi, and samples miso on each sclk rising edge.
- Returns the received word with a one-cycle done pulse.
- Sits between the on-chip control logic and the external SPI pins.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_master_if.sv | 14 +
 rtl/spi_clk_div.sv | 20 ++
 rtl/spi_master.sv | 80 ++++++++
 tb/tb_spi_master.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: state encodings and SPI mode constants shared by the spi_master slice.
package spi_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t SHIFT_LO = 3'd1;
    localparam state_t SHIFT_HI = 3'd2;
    localparam state_t HOLD     = 3'd3;
    localparam state_t DONE     = 3'd4;
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: parallel request/response signals plus the SPI pins of one initiator.
interface spi_master_if #(parameter int DATA_W = 8);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    modport master (input start, tx_data, miso, output busy, done, rx_data, sclk, cs_n, mosi);
    modport slave (output start, tx_data, miso, input busy, done, rx_data, sclk, cs_n, mosi);
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: one-cycle tick every CLK_DIV enabled cycles; restart or disable reloads to 0.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = enable && !restart && cnt == TOP;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (restart || !enable || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator; shifts DATA_W bits MSB first and returns the received word.
// All pin outputs are registered from the next-state decode, so none depend combinationally on inputs.
module spi_master import spi_pkg::*; #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input logic          clk,
    input logic          rst_n,
    spi_master_if.master bus
);
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
    state_t            state, state_nxt;
    logic              tick, last, accept, shift, sample, active;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DATA_W-1:0] tx_sr, tx_nxt, rx_sr, rx_nxt, rx_data_nxt;
    logic              sclk_nxt, cs_nxt, mosi_nxt, busy_nxt, done_nxt;
    assign active = state inside {SHIFT_LO, SHIFT_HI, HOLD};
    assign last   = bit_cnt == LAST;
    assign accept = state == IDLE && bus.start;
    assign shift  = state == SHIFT_HI && tick && !last;
    assign sample = tick && state == (CPHA ? SHIFT_HI : SHIFT_LO);
    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk(clk),
        .rst_n(rst_n),
        .enable(active),
        .restart(state == IDLE),
        .tick(tick)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = bus.start ? SHIFT_LO : IDLE;
            SHIFT_LO: state_nxt = tick ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: state_nxt = tick ? (last ? HOLD : SHIFT_LO) : SHIFT_HI;
            HOLD:     state_nxt = tick ? DONE : HOLD;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
    // Outputs are decoded from the upcoming state so they change on the same edge as the state.
    always_comb begin
        tx_nxt      = accept ? bus.tx_data : shift ? tx_sr << 1 : tx_sr;
        rx_nxt      = accept ? '0 : sample ? {rx_sr[DATA_W-2:0], bus.miso} : rx_sr;
        bit_nxt     = accept ? '0 : shift ? bit_cnt + 1'b1 : bit_cnt;
        sclk_nxt    = state_nxt == SHIFT_HI ? ~CPOL : CPOL;
        cs_nxt      = !(state_nxt inside {SHIFT_LO, SHIFT_HI, HOLD});
        mosi_nxt    = state_nxt == IDLE ? 1'b0 : tx_nxt[DATA_W-1];
        busy_nxt    = state_nxt != IDLE;
        done_nxt    = state_nxt == DONE;
        rx_data_nxt = state_nxt == DONE ? rx_sr : bus.rx_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            bus.sclk    <= CPOL;
            bus.cs_n    <= 1'b1;
            bus.mosi    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rx_data <= '0;
        end else begin
            tx_sr       <= tx_nxt;
            rx_sr       <= rx_nxt;
            bit_cnt     <= bit_nxt;
            bus.sclk    <= sclk_nxt;
            bus.cs_n    <= cs_nxt;
            bus.mosi    <= mosi_nxt;
            bus.busy    <= busy_nxt;
            bus.done    <= done_nxt;
            bus.rx_data <= rx_data_nxt;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for two spi_master instances (CLK_DIV=2 and CLK_DIV=1).
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst_n, start, sel;
    logic [7:0] tx;
    logic [1:0] mode;
    int         cyc = 0, n_chk = 0, n_fail = 0, t0, cd;
    typedef struct { logic [7:0] tx; logic [7:0] rx; int t0; } exp_t;
    exp_t sb[$];

    spi_master_if #(.DATA_W(8)) bus2 ();
    spi_master_if #(.DATA_W(8)) bus1 ();
    spi_master #(.DATA_W(8), .CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    spi_master #(.DATA_W(8), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus2.start   = start & ~sel;
    assign bus1.start   = start & sel;
    assign bus2.tx_data = tx;
    assign bus1.tx_data = tx;
    assign bus2.miso    = mode == 2'd0 ? bus2.mosi : mode == 2'd1;
    assign bus1.miso    = mode == 2'd0 ? bus1.mosi : mode == 2'd1;

    logic       v_sclk, v_cs_n, v_mosi, v_busy, v_done;
    logic [7:0] v_rx;
    assign v_sclk = sel ? bus1.sclk : bus2.sclk;
    assign v_cs_n = sel ? bus1.cs_n : bus2.cs_n;
    assign v_mosi = sel ? bus1.mosi : bus2.mosi;
    assign v_busy = sel ? bus1.busy : bus2.busy;
    assign v_done = sel ? bus1.done : bus2.done;
    assign v_rx   = sel ? bus1.rx_data : bus2.rx_data;
    assign cd     = sel ? 1 : 2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Loopback returns the transmitted word; a tied pin returns all ones or all zeros.
    function automatic logic [7:0] model_rx(input logic [7:0] t, input logic [1:0] m);
        return m == 2'd0 ? t : m == 2'd1 ? 8'hFF : 8'h00;
    endfunction

    int         rises, hi_len, cs_hi;
    logic [7:0] cap;
    logic [7:0] hold_rx [2];
    logic       prev_sclk, prev_cs, after_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_sclk", v_sclk, 0);
            check("rst_cs_n", v_cs_n, 1);
            check("rst_busy", v_busy, 0);
            check("rst_done", v_done, 0);
            check("rst_mosi", v_mosi, 0);
            check("rst_rx_data", v_rx, 0);
            sb.delete();
            rises = 0; cap = 0; hi_len = 0; cs_hi = 2;
            prev_sclk = 0; prev_cs = 1; after_done = 0;
            hold_rx[0] = 0; hold_rx[1] = 0;
        end else begin
            if (after_done) begin
                check("post_done_busy", v_busy, 0);
                check("post_done_cs_n", v_cs_n, 1);
                check("post_done_mosi", v_mosi, 0);
                after_done = 0;
            end
            if (prev_cs && !v_cs_n) begin
                check("cs_high_gap_ge2", int'(cs_hi >= 2), 1);
                if (sb.size() == 0) check("unexpected_start", 1, 0);
                else check("cs_fall_cycle", cyc, sb[0].t0 + 1);
                rises = 0; cap = 0;
            end
            cs_hi = v_cs_n ? cs_hi + 1 : 0;
            if (!prev_sclk && v_sclk) begin
                cap = {cap[6:0], v_mosi};
                if (sb.size() != 0) check("rise_cycle", cyc, sb[0].t0 + 1 + cd * (2 * rises + 1));
                rises++;
                hi_len = 0;
            end
            if (v_sclk) hi_len++;
            if (prev_sclk && !v_sclk) check("sclk_high_len", hi_len, cd);
            if (v_done) begin
                if (sb.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    check("rx_data", v_rx, sb[0].rx);
                    check("done_cycle", cyc, sb[0].t0 + 1 + cd * 17);
                    check("mosi_bits", cap, sb[0].tx);
                    check("rise_count", rises, 8);
                    hold_rx[sel] = sb[0].rx;
                    void'(sb.pop_front());
                end
                after_done = 1;
            end else check("rx_hold", v_rx, hold_rx[sel]);
            prev_sclk = v_sclk;
            prev_cs = v_cs_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("drain_in_time", sb.size(), 0);
        repeat (2) step();
    endtask

    task automatic go(input logic [7:0] t, input logic s, input logic [1:0] m);
        step();
        sel = s; mode = m; tx = t; start = 1'b1;
        sb.push_back('{t, model_rx(t, m), cyc});
        step();
        start = 1'b0;
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; sel = 1'b0; mode = 2'd0; tx = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        go(8'hA5, 1'b0, 2'd0);
        go(8'h00, 1'b0, 2'd1);
        // start held and tx_data changed mid-transfer: one transfer of the captured word
        step();
        sel = 1'b0; mode = 2'd0; tx = 8'h81; start = 1'b1; t0 = cyc;
        sb.push_back('{8'h81, 8'h81, t0});
        repeat (5) step();
        tx = 8'h3C;
        repeat (15) step();
        start = 1'b0;
        drain();
        // start still high in IDLE re-triggers with the word present then
        step();
        tx = 8'h81; start = 1'b1; t0 = cyc;
        sb.push_back('{8'h81, 8'h81, t0});
        sb.push_back('{8'h3C, 8'h3C, t0 + 36});
        repeat (5) step();
        tx = 8'h3C;
        while (cyc < t0 + 37) step();
        start = 1'b0;
        drain();
        // asynchronous abort mid-transfer, then a clean transfer
        step();
        tx = 8'hC3; start = 1'b1; t0 = cyc;
        sb.push_back('{8'hC3, 8'hC3, t0});
        step();
        start = 1'b0;
        while (cyc < t0 + 12) step();
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        go(8'h96, 1'b0, 2'd0);
        go(8'h5A, 1'b1, 2'd0);
        // back-to-back: second start in the first IDLE cycle after done
        step();
        sel = 1'b0; mode = 2'd0; tx = 8'h12; start = 1'b1; t0 = cyc;
        sb.push_back('{8'h12, 8'h12, t0});
        step();
        start = 1'b0;
        while (cyc < t0 + 36) step();
        tx = 8'hFE; start = 1'b1;
        sb.push_back('{8'hFE, 8'hFE, cyc});
        step();
        start = 1'b0;
        drain();
        repeat (20) go(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
